shape_processor_ctrl_responder: RTL and testbench



---
 rtl/shape_processor_ctrl_responder.sv | 156 +++++++++++++++
 tb/tb_shape_processor_ctrl_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_processor_ctrl_responder.sv
// ---------------------------------------------------------------------------
// shape_processor_ctrl_responder
//
// Bus-side responder for the shape processor CTRL register. It serves
// single-beat reads and writes, checks every write against the SHAPE /
// OPERATION legality rules, holds the committed CTRL value, and launches the
// compute engine with a one-cycle start pulse for each legal write. While
// the engine is busy, writes stall until the engine reports done.
//
// CTRL layout: [31:18] reserved, [17:16] SHAPE, [15:5] reserved,
//              [4:0] OPERATION. Reserved bits are ignored and read as 0.
//
// Handshake: the initiator raises write or read, and holds it until it sees
// ready. ready is a one-cycle pulse in the cycle after the request is
// sampled. error and rdata are only meaningful while ready is high, and are 0
// otherwise. After ready, the responder ignores the request lines for that
// cycle, so a request dropped by the next cycle is never accepted twice. If
// write and read are both high while not busy, the write wins and the read
// gets no response.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   write      in   write request
//   read       in   read request
//   wdata      in   write data (32)
//   done       in   engine completion pulse; ignored while not busy
//   ready      out  request completion pulse
//   error      out  1 = write rejected (valid with ready)
//   rdata      out  CTRL readback (valid with ready on a read)
//   start      out  engine launch pulse, with ready of a legal write
//   shape      out  committed SHAPE (2)
//   operation  out  committed OPERATION (5)
//   dbg_state  out  bus FSM state (0 IDLE, 1 RESP)
//   dbg_busy   out  engine busy flag
// ---------------------------------------------------------------------------
module shape_processor_ctrl_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] wdata,
    input  logic        done,
    output logic        ready,
    output logic        error,
    output logic [31:0] rdata,
    output logic        start,
    output logic [1:0]  shape,
    output logic [4:0]  operation,
    output logic        dbg_state,
    output logic        dbg_busy
);

    localparam logic [1:0] SHAPE_KEEP      = 2'b00;
    localparam logic [1:0] SHAPE_RECTANGLE = 2'b01;
    localparam logic [1:0] SHAPE_TRIANGLE  = 2'b10;

    localparam logic [4:0] OP_PERIMETER      = 5'b00000;
    localparam logic [4:0] OP_AREA           = 5'b00001;
    localparam logic [4:0] OP_IS_SQUARE      = 5'b01000;
    localparam logic [4:0] OP_IS_EQUILATERAL = 5'b10000;
    localparam logic [4:0] OP_IS_ISOSCELES   = 5'b10001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t state;
    logic   busy;

    logic [1:0] shape_field;
    logic [4:0] op_field;
    logic [1:0] eff_shape;
    logic       write_legal;

    // Reserved write bits have no function; fold them into a named sink.
    logic unused_reserved;
    assign unused_reserved = ^{wdata[31:18], wdata[15:5]};

    assign shape_field = wdata[17:16];
    assign op_field    = wdata[4:0];

    // KEEP_SHAPE means "combine the new operation with the committed shape".
    assign eff_shape = (shape_field == SHAPE_KEEP) ? shape : shape_field;

    always_comb begin
        write_legal = 1'b0;
        if (shape_field != 2'b11) begin
            case (op_field)
                OP_PERIMETER,
                OP_AREA:           write_legal = 1'b1;
                OP_IS_SQUARE:      write_legal = (eff_shape == SHAPE_RECTANGLE);
                OP_IS_EQUILATERAL,
                OP_IS_ISOSCELES:   write_legal = (eff_shape == SHAPE_TRIANGLE);
                default:           write_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ready     <= 1'b0;
            error     <= 1'b0;
            rdata     <= 32'h0;
            start     <= 1'b0;
            shape     <= SHAPE_RECTANGLE;
            operation <= OP_PERIMETER;
        end else begin
            // Response outputs are pulses; they fall back to 0 by default.
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= 32'h0;
            start <= 1'b0;

            // busy can only be set while it is clear, so this never
            // collides with the set below.
            if (busy && done) begin
                busy <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (write && !busy) begin
                        ready <= 1'b1;
                        state <= S_RESP;
                        if (write_legal) begin
                            start     <= 1'b1;
                            shape     <= eff_shape;
                            operation <= op_field;
                            busy      <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end else if (read) begin
                        ready <= 1'b1;
                        rdata <= {14'b0, shape, 11'b0, operation};
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // ready is on the outputs this cycle; request lines are
                    // ignored so the same request is not taken twice.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_busy  = busy;

endmodule

// File: tb/tb_shape_processor_ctrl_responder.sv
module tb_shape_processor_ctrl_responder;

    logic        clk;
    logic        rst;
    logic        write;
    logic        read;
    logic [31:0] wdata;
    logic        done;
    logic        ready;
    logic        error;
    logic [31:0] rdata;
    logic        start;
    logic [1:0]  shape;
    logic [4:0]  operation;
    logic        dbg_state;
    logic        dbg_busy;

    int errors = 0;
    int checks = 0;

    shape_processor_ctrl_responder dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .read      (read),
        .wdata     (wdata),
        .done      (done),
        .ready     (ready),
        .error     (error),
        .rdata     (rdata),
        .start     (start),
        .shape     (shape),
        .operation (operation),
        .dbg_state (dbg_state),
        .dbg_busy  (dbg_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // All inputs change 1 time unit after a rising edge; outputs are sampled
    // at the same point, i.e. away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one write; returns the response seen in the following cycle,
    // then drops the request and lets the FSM return to IDLE.
    task automatic bus_write(input logic [31:0] d, output logic r, output logic e,
                             output logic s, output logic [31:0] rd);
        write = 1'b1;
        wdata = d;
        tick();
        r  = ready;
        e  = error;
        s  = start;
        rd = rdata;
        write = 1'b0;
        wdata = 32'h0;
        tick();
    endtask

    task automatic bus_read(output logic r, output logic e, output logic [31:0] rd);
        read = 1'b1;
        tick();
        r  = ready;
        e  = error;
        rd = rdata;
        read = 1'b0;
        tick();
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic r, e;
        logic [31:0] rd;
        rst   = 1'b1;
        write = 1'b1;
        wdata = 32'h0002_0010;
        tick();
        tick();
        checks++;
        if ({ready, error, rdata, start, shape, operation} !== {1'b0, 1'b0, 32'h0, 1'b0, 2'b01, 5'b00000}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b error=%b rdata=%h start=%b shape=%b op=%b, need 0 0 00000000 0 01 00000",
                     ready, error, rdata, start, shape, operation);
        end
        rst   = 1'b0;
        write = 1'b0;
        wdata = 32'h0;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_ready: ready=%b need 0", ready);
        end
        bus_read(r, e, rd);
        checks++;
        if ({r, e, rd} !== {1'b1, 1'b0, 32'h0001_0000}) begin
            errors++;
            $display("FAIL reset_readback: ready=%b error=%b rdata=%h, need 1 0 00010000", r, e, rd);
        end
    endtask

    task automatic test_legal_write();
        logic r, e, s;
        logic [31:0] rd;
        bus_write(32'h0002_0010, r, e, s, rd);
        checks++;
        if ({r, s, e, rd} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL legal_write_resp: ready=%b start=%b error=%b rdata=%h, need 1 1 0 00000000", r, s, e, rd);
        end
        checks++;
        if ({shape, operation} !== {2'b10, 5'b10000}) begin
            errors++;
            $display("FAIL legal_write_ctrl: shape=%b op=%b, need 10 10000", shape, operation);
        end
        // read while busy is still served
        bus_read(r, e, rd);
        checks++;
        if ({r, e, rd} !== {1'b1, 1'b0, 32'h0002_0010}) begin
            errors++;
            $display("FAIL legal_write_readback: ready=%b error=%b rdata=%h, need 1 0 00020010", r, e, rd);
        end
        pulse_done();
    endtask

    task automatic test_illegal_writes();
        logic [31:0] vec [3];
        logic r, e, s;
        logic [31:0] rd;
        vec[0] = 32'h0001_0010;   // IS_EQUILATERAL on RECTANGLE
        vec[1] = 32'h0003_0000;   // SHAPE=11
        vec[2] = 32'h0001_0002;   // undefined OPERATION
        for (int i = 0; i < 3; i++) begin
            bus_write(vec[i], r, e, s, rd);
            checks++;
            if ({r, e, s, shape, operation} !== {1'b1, 1'b1, 1'b0, 2'b10, 5'b10000}) begin
                errors++;
                $display("FAIL illegal_write_%0d: ready=%b error=%b start=%b shape=%b op=%b, need 1 1 0 10 10000",
                         i, r, e, s, shape, operation);
            end
        end
        bus_read(r, e, rd);
        checks++;
        if (rd !== 32'h0002_0010) begin
            errors++;
            $display("FAIL illegal_readback: rdata=%h need 00020010", rd);
        end
    endtask

    task automatic test_keep_shape();
        logic r, e, s;
        logic [31:0] rd;
        bus_write(32'h0000_0011, r, e, s, rd);
        checks++;
        if ({r, e, s, shape, operation} !== {1'b1, 1'b0, 1'b1, 2'b10, 5'b10001}) begin
            errors++;
            $display("FAIL keep_shape_legal: ready=%b error=%b start=%b shape=%b op=%b, need 1 0 1 10 10001",
                     r, e, s, shape, operation);
        end
        pulse_done();
        bus_write(32'h0000_0008, r, e, s, rd);
        checks++;
        if ({r, e, s, shape, operation} !== {1'b1, 1'b1, 1'b0, 2'b10, 5'b10001}) begin
            errors++;
            $display("FAIL keep_shape_illegal: ready=%b error=%b start=%b shape=%b op=%b, need 1 1 0 10 10001",
                     r, e, s, shape, operation);
        end
    endtask

    task automatic test_busy_stall();
        logic r, e, s;
        logic [31:0] rd;
        int seen_ready;
        bus_write(32'h0001_0001, r, e, s, rd);   // RECTANGLE, AREA
        checks++;
        if ({r, e, s, shape, operation} !== {1'b1, 1'b0, 1'b1, 2'b01, 5'b00001}) begin
            errors++;
            $display("FAIL busy_first_write: ready=%b error=%b start=%b shape=%b op=%b, need 1 0 1 01 00001",
                     r, e, s, shape, operation);
        end
        // second write held for 10 cycles with done low: must stall
        write = 1'b1;
        wdata = 32'h0001_0008;                   // RECTANGLE, IS_SQUARE
        seen_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready !== 1'b0) seen_ready++;
        end
        checks++;
        if (seen_ready != 0) begin
            errors++;
            $display("FAIL busy_stall: ready seen %0d times during stall, need 0", seen_ready);
        end
        // a read during the busy period completes in 2 cycles
        write = 1'b0;
        read  = 1'b1;
        tick();
        checks++;
        if ({ready, error, rdata} !== {1'b1, 1'b0, 32'h0001_0001}) begin
            errors++;
            $display("FAIL busy_read: ready=%b error=%b rdata=%h, need 1 0 00010001", ready, error, rdata);
        end
        read = 1'b0;
        tick();
        checks++;
        if ({ready, dbg_busy} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL busy_read_end: ready=%b busy=%b, need 0 1", ready, dbg_busy);
        end
        // resume the stalled write, then release it with done
        write = 1'b1;
        tick();
        done = 1'b1;                              // cycle M
        tick();                                   // cycle M+1
        done = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_m1: ready=%b need 0", ready);
        end
        tick();                                   // cycle M+2
        checks++;
        if ({ready, start, error, shape, operation} !== {1'b1, 1'b1, 1'b0, 2'b01, 5'b01000}) begin
            errors++;
            $display("FAIL busy_release: ready=%b start=%b error=%b shape=%b op=%b, need 1 1 0 01 01000",
                     ready, start, error, shape, operation);
        end
        write = 1'b0;
        wdata = 32'h0;
        tick();
        pulse_done();
    endtask

    task automatic test_reserved_bits();
        logic r, e, s;
        logic [31:0] rd;
        // done while idle must have no effect
        pulse_done();
        bus_write(32'hFFFC_FFE1, r, e, s, rd);
        checks++;
        if ({r, e, s, shape, operation} !== {1'b1, 1'b0, 1'b1, 2'b01, 5'b00001}) begin
            errors++;
            $display("FAIL reserved_write: ready=%b error=%b start=%b shape=%b op=%b, need 1 0 1 01 00001",
                     r, e, s, shape, operation);
        end
        bus_read(r, e, rd);
        checks++;
        if (rd !== 32'h0001_0001) begin
            errors++;
            $display("FAIL reserved_readback: rdata=%h need 00010001", rd);
        end
        pulse_done();
    endtask

    task automatic test_back_to_back();
        int ready_cnt;
        // read held continuously for 6 cycles: one response every 2 cycles
        read = 1'b1;
        ready_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready === 1'b1) ready_cnt++;
        end
        read = 1'b0;
        tick();
        checks++;
        if (ready_cnt != 3) begin
            errors++;
            $display("FAIL back_to_back: ready count=%0d need 3", ready_cnt);
        end
        // write and read together: write wins, no read data
        write = 1'b1;
        read  = 1'b1;
        wdata = 32'h0002_0000;                    // TRIANGLE, PERIMETER
        tick();
        checks++;
        if ({ready, error, start, rdata, shape, operation} !== {1'b1, 1'b0, 1'b1, 32'h0, 2'b10, 5'b00000}) begin
            errors++;
            $display("FAIL write_read_collision: ready=%b error=%b start=%b rdata=%h shape=%b op=%b, need 1 0 1 00000000 10 00000",
                     ready, error, start, rdata, shape, operation);
        end
        write = 1'b0;
        read  = 1'b0;
        wdata = 32'h0;
        tick();
        pulse_done();
    endtask

    initial begin
        rst   = 1'b1;
        write = 1'b0;
        read  = 1'b0;
        wdata = 32'h0;
        done  = 1'b0;
        tick();
        test_reset();
        test_legal_write();
        test_illegal_writes();
        test_keep_shape();
        test_busy_stall();
        test_reserved_bits();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
